// File: rtl/parking_entry_controller.sv
// Multi-lane parking entry controller: owns the free-slot counter, arbitrates
// entry lanes round-robin and drives a timed gate-open pulse per granted car.
module parking_entry_controller #(
  parameter int N_LANES     = 2,
  parameter int CAP_WIDTH   = 8,
  parameter int CAPACITY    = 200,
  parameter int OPEN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_LANES-1:0]   entry_req,
  input  logic                 exit_pulse,
  output logic [N_LANES-1:0]   entry_grant,
  output logic [N_LANES-1:0]   gate_open,
  output logic [CAP_WIDTH-1:0] free_slots,
  output logic                 full,
  output logic                 exit_err
);

  localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int CNT_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [CAP_WIDTH-1:0] CAP_VAL  = CAP_WIDTH'(CAPACITY);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(OPEN_CYCLES - 1);

  typedef enum logic {IDLE, OPEN} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_lane;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_sel_valid;
  logic [PTR_W-1:0]   w_sel_idx;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [N_LANES-1:0] w_sel_onehot;
  logic               w_grant;
  logic               w_inc;
  logic [CAP_WIDTH-1:0] w_free_next;

  // Scan from the farthest offset down so the lane nearest the pointer wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (entry_req[(int'(r_ptr) + i) % N_LANES]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = PTR_W'((int'(r_ptr) + i) % N_LANES);
      end
    end
  end

  assign w_next_ptr   = PTR_W'((int'(w_sel_idx) + 1) % N_LANES);
  assign w_sel_onehot = N_LANES'(1) << w_sel_idx;
  assign w_grant      = (r_state == IDLE) && w_sel_valid && (free_slots != '0);
  assign w_inc        = exit_pulse && (free_slots != CAP_VAL);

  // A simultaneous grant and returned slot cancel out.
  always_comb begin
    w_free_next = free_slots;
    unique case ({w_grant, w_inc})
      2'b10:   w_free_next = free_slots - 1'b1;
      2'b01:   w_free_next = free_slots + 1'b1;
      default: w_free_next = free_slots;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_lane      <= '0;
      r_cnt       <= '0;
      entry_grant <= '0;
      gate_open   <= '0;
      free_slots  <= CAP_VAL;
      full        <= 1'b0;
      exit_err    <= 1'b0;
    end else begin
      free_slots  <= w_free_next;
      full        <= (w_free_next == '0);
      entry_grant <= '0;
      if (exit_pulse && (free_slots == CAP_VAL)) begin
        exit_err <= 1'b1;
      end

      unique case (r_state)
        IDLE: begin
          gate_open <= '0;
          if (w_grant) begin
            entry_grant <= w_sel_onehot;
            r_lane      <= w_sel_idx;
            r_ptr       <= w_next_ptr;
            r_cnt       <= CNT_LOAD;
            r_state     <= OPEN;
          end
        end
        OPEN: begin
          // Gate stays up through the IDLE cycle that follows, giving OPEN_CYCLES total.
          gate_open <= N_LANES'(1) << r_lane;
          if (r_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_entry_controller.sv
// Self-checking bench for parking_entry_controller: directed scenarios plus
// randomized traffic compared against a timestamp-based reference model.
module tb_parking_entry_controller;

  localparam int N     = 2;
  localparam int CAP_W = 8;
  localparam int CAP   = 200;
  localparam int OC    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N-1:0]     entry_req = '0;
  logic             exit_pulse = 1'b0;
  logic [N-1:0]     entry_grant;
  logic [N-1:0]     gate_open;
  logic [CAP_W-1:0] free_slots;
  logic             full;
  logic             exit_err;

  parking_entry_controller #(
    .N_LANES(N), .CAP_WIDTH(CAP_W), .CAPACITY(CAP), .OPEN_CYCLES(OC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_pulse(exit_pulse),
    .entry_grant(entry_grant), .gate_open(gate_open), .free_slots(free_slots),
    .full(full), .exit_err(exit_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: slot count, pointer and time windows indexed by edge number.
  int m_free, m_ptr, m_n, m_next_ok, m_gate_first, m_gate_last, m_gate_lane, m_grant_lane;
  bit m_err;
  bit hold_reqs = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_free = CAP; m_ptr = 0; m_err = 1'b0; m_next_ok = m_n;
    m_gate_first = 1; m_gate_last = 0; m_gate_lane = 0; m_grant_lane = -1;
  endtask

  task automatic model_step();
    int inc;
    m_n++;
    m_grant_lane = -1;
    if (m_n >= m_next_ok && entry_req != '0 && m_free > 0) begin
      for (int i = 0; i < N; i++) begin
        if (m_grant_lane < 0 && entry_req[(m_ptr + i) % N]) m_grant_lane = (m_ptr + i) % N;
      end
      m_ptr        = (m_grant_lane + 1) % N;
      m_next_ok    = m_n + OC + 1;
      m_gate_first = m_n + 1;
      m_gate_last  = m_n + OC;
      m_gate_lane  = m_grant_lane;
    end
    inc = (exit_pulse && m_free != CAP) ? 1 : 0;
    if (exit_pulse && m_free == CAP) m_err = 1'b1;
    m_free = m_free + inc - ((m_grant_lane >= 0) ? 1 : 0);
  endtask

  // One clock: model predicts, DUT is sampled 1ns after the edge, inputs then
  // return to the caller at the following falling edge.
  task automatic cycle();
    logic [N-1:0] exp_grant, exp_gate;
    model_step();
    exp_grant = (m_grant_lane >= 0) ? N'(1) << m_grant_lane : '0;
    exp_gate  = (m_n >= m_gate_first && m_n <= m_gate_last) ? N'(1) << m_gate_lane : '0;
    @(posedge clk); #1;
    check("grant", 32'(entry_grant), 32'(exp_grant));
    check("gate",  32'(gate_open),   32'(exp_gate));
    check("free",  32'(free_slots),  32'(m_free));
    check("full",  32'(full),        32'(m_free == 0));
    check("err",   32'(exit_err),    32'(m_err));
    if (m_grant_lane >= 0 && !hold_reqs) entry_req[m_grant_lane] = 1'b0;
    exit_pulse = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_grant", 32'(entry_grant), 32'd0);
    check("rst_gate",  32'(gate_open),   32'd0);
    check("rst_free",  32'(free_slots),  32'(CAP));
    check("rst_full",  32'(full),        32'd0);
    check("rst_err",   32'(exit_err),    32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_inputs(input bit allow_exit);
    for (int l = 0; l < N; l++) begin
      if (!entry_req[l] && $urandom_range(0, 3) == 0) entry_req[l] = 1'b1;
    end
    exit_pulse = allow_exit && ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    int budget;
    m_n = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single lane: one grant, four gate cycles, back to idle.
    entry_req = 2'b01;
    cycle();
    check("t1_grant", 32'(entry_grant), 32'd1);
    check("t1_free",  32'(free_slots),  32'd199);
    repeat (4) cycle();
    check("t1_gate_last", 32'(gate_open), 32'd1);
    cycle();
    check("t1_gate_off", 32'(gate_open), 32'd0);

    // Both lanes held: grants alternate 0,1,0 five cycles apart.
    do_reset();
    hold_reqs = 1'b1;
    entry_req = 2'b11;
    repeat (11) cycle();
    check("t2_grant3", 32'(entry_grant), 32'd1);
    check("t2_free",   32'(free_slots),  32'd197);
    hold_reqs = 1'b0;
    entry_req = '0;
    repeat (6) cycle();

    // Exit at full capacity saturates and sets the sticky error.
    do_reset();
    exit_pulse = 1'b1;
    cycle();
    check("t4_free", 32'(free_slots), 32'(CAP));
    check("t4_err",  32'(exit_err),   32'd1);
    repeat (3) cycle();
    check("t4_sticky", 32'(exit_err), 32'd1);
    do_reset();

    // Random traffic with occasional exits until 50 slots remain.
    budget = 0;
    while (m_free != 50 && budget < 5000) begin
      random_inputs(1'b1);
      cycle();
      budget++;
    end
    check("reach50", 32'(free_slots), 32'd50);

    // Exit coincident with a grant: net zero, gate opens.
    while (m_n + 1 < m_next_ok) cycle();
    if (entry_req == '0) entry_req[$urandom_range(0, N - 1)] = 1'b1;
    exit_pulse = 1'b1;
    cycle();
    check("t5_free",   32'(free_slots), 32'd50);
    check("t5_grant",  32'(entry_grant != '0), 32'd1);
    cycle();
    check("t5_gate",   32'(gate_open != '0), 32'd1);

    // Drain to empty, then verify requests are ignored while full.
    budget = 0;
    while (m_free != 0 && budget < 3000) begin
      random_inputs(1'b0);
      cycle();
      budget++;
    end
    check("drained", 32'(free_slots), 32'd0);
    entry_req = 2'b11;
    repeat (8) cycle();
    check("t3_full",   32'(full),        32'd1);
    check("t3_nogrnt", 32'(entry_grant), 32'd0);
    exit_pulse = 1'b1;
    cycle();
    check("t3_free1", 32'(free_slots), 32'd1);
    check("t3_notfull", 32'(full), 32'd0);
    cycle();
    check("t3_regrant", 32'(entry_grant != '0), 32'd1);
    check("t3_full2", 32'(full), 32'd1);
    repeat (6) cycle();

    // Reset in the second OPEN cycle: gate drops at once, pointer back to lane 0.
    do_reset();
    entry_req = 2'b01;
    repeat (3) cycle();
    entry_req = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_gate", 32'(gate_open),  32'd0);
    check("t6_free", 32'(free_slots), 32'(CAP));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("t6_lane0", 32'(entry_grant), 32'd1);
    repeat (6) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
